// File: rtl/fp16_div_seq_if.sv
// Request/response bundle for the sequential binary16 divider.
interface fp16_div_seq_if;
  logic        start;
  logic [15:0] input_a;
  logic [15:0] input_b;
  logic [15:0] div_output;
  logic        busy;
  logic        done;

  modport master (output start, input_a, input_b, input div_output, busy, done);
  modport slave  (input start, input_a, input_b, output div_output, busy, done);
endinterface

// File: rtl/fp16_div_seq.sv
// Sequential IEEE-754 binary16 divider: restoring division, one quotient bit
// per cycle, round to nearest even, fixed 17-cycle latency.
// Build option: define FDIV_SUBNORMAL_EN to normalize subnormal operands and
// produce subnormal results; otherwise subnormals flush to signed zero.
module fp16_div_seq (
  input  logic          clk,
  input  logic          rst,
  fp16_div_seq_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] DIVIDE = 3'd2;
  localparam logic [2:0] ROUND  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // m carries the hidden bit; e is a two's-complement biased exponent
  typedef struct packed {
    logic [10:0] m;
    logic [7:0]  e;
  } opnd_t;

  function automatic opnd_t unpack_op(input logic [15:0] x);
    opnd_t r;
    r.m = {1'b1, x[9:0]};
    r.e = {3'b000, x[14:10]};
    if (x[14:10] == 5'd0) begin
      r.m = {1'b0, x[9:0]};
      r.e = 8'd1;
`ifdef FDIV_SUBNORMAL_EN
      // leading-zero normalize so bit 10 is set
      for (int i = 0; i < 10; i++)
        if (!r.m[10]) begin
          r.m = r.m << 1;
          r.e = r.e - 8'd1;
        end
`endif
    end
    return r;
  endfunction

  logic [2:0]        state;
  logic [3:0]        div_cnt;
  logic [15:0]       a_q, b_q;
  logic              sign_q;
  logic signed [7:0] exp_q;
  logic [10:0]       mb_q;
  logic [11:0]       rem_q;
  logic [13:0]       quo_q;
  logic              spec_q;
  logic [15:0]       spec_val_q;
  logic [15:0]       res_q;
  logic [15:0]       div_output_q;
  logic              done_q;

  assign bus.busy       = (state != IDLE);
  assign bus.div_output = div_output_q;
  assign bus.done       = done_q;

  opnd_t ua, ub;
  assign ua = unpack_op(a_q);
  assign ub = unpack_op(b_q);

  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign_c;
  logic spec_c;
  logic [15:0] spec_val_c;

  // special-case classification of the latched operands
  always_comb begin
    sign_c = a_q[15] ^ b_q[15];
    nan_a  = (a_q[14:10] == 5'h1F) && (a_q[9:0] != 10'd0);
    nan_b  = (b_q[14:10] == 5'h1F) && (b_q[9:0] != 10'd0);
    inf_a  = (a_q[14:10] == 5'h1F) && (a_q[9:0] == 10'd0);
    inf_b  = (b_q[14:10] == 5'h1F) && (b_q[9:0] == 10'd0);
`ifdef FDIV_SUBNORMAL_EN
    zero_a = (a_q[14:0] == 15'd0);
    zero_b = (b_q[14:0] == 15'd0);
`else
    zero_a = (a_q[14:10] == 5'd0);
    zero_b = (b_q[14:10] == 5'd0);
`endif
    spec_c     = 1'b1;
    spec_val_c = 16'h7E00;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
      spec_val_c = 16'h7E00;
    else if (inf_a || zero_b)
      spec_val_c = {sign_c, 15'h7C00};
    else if (zero_a || inf_b)
      spec_val_c = {sign_c, 15'h0000};
    else
      spec_c = 1'b0;
  end

  logic        ge;
  logic [11:0] rem_sel, rem_nxt;

  // one restoring-division step: subtract if it fits, then shift
  always_comb begin
    ge      = (rem_q >= {1'b0, mb_q});
    rem_sel = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_nxt = rem_sel << 1;
  end

  logic [13:0]       n;
  logic signed [7:0] ef;
  logic              stk, uf, g, inc;
  logic [9:0]        mant;
  logic [4:0]        efld;
  logic [14:0]       sum;
  logic [15:0]       res_c;
`ifdef FDIV_SUBNORMAL_EN
  int                sh;
`endif

  // normalize, denormalize if needed, round to nearest even, pack
  always_comb begin
    n   = quo_q[13] ? quo_q : {quo_q[12:0], 1'b0};
    ef  = quo_q[13] ? exp_q : exp_q - 8'sd1;
    stk = |rem_q;
    uf  = (ef <= 8'sd0);
`ifdef FDIV_SUBNORMAL_EN
    sh = 1 - int'(ef);
    if (uf)
      for (int i = 0; i < 14; i++)
        if (i < sh) begin
          stk = stk | n[0];
          n   = n >> 1;
        end
`endif
    mant  = n[12:3];
    g     = n[2];
    stk   = stk | (|n[1:0]);
    inc   = g & (stk | n[3]);
    efld  = uf ? 5'd0 : ef[4:0];
    sum   = {efld, mant} + {14'd0, inc};
    if ((ef >= 8'sd31) || (sum >= 15'h7C00))
      res_c = {sign_q, 15'h7C00};
    else
      res_c = {sign_q, sum};
`ifndef FDIV_SUBNORMAL_EN
    if (uf) res_c = {sign_q, 15'h0000};
`endif
    if (spec_q) res_c = spec_val_q;
  end

  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= 4'd0;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      sign_q       <= 1'b0;
      exp_q        <= 8'sd0;
      mb_q         <= 11'd0;
      rem_q        <= 12'd0;
      quo_q        <= 14'd0;
      spec_q       <= 1'b0;
      spec_val_q   <= 16'd0;
      res_q        <= 16'd0;
      div_output_q <= 16'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_q   <= bus.input_a;
          b_q   <= bus.input_b;
          state <= UNPACK;
        end
        UNPACK: begin
          sign_q     <= sign_c;
          exp_q      <= $signed(ua.e) - $signed(ub.e) + 8'sd15;
          mb_q       <= ub.m;
          rem_q      <= {1'b0, ua.m};
          quo_q      <= 14'd0;
          spec_q     <= spec_c;
          spec_val_q <= spec_val_c;
          div_cnt    <= 4'd13;
          state      <= DIVIDE;
        end
        DIVIDE: begin
          quo_q <= {quo_q[12:0], ge};
          rem_q <= rem_nxt;
          if (div_cnt == 4'd0) state <= ROUND;
          else div_cnt <= div_cnt - 4'd1;
        end
        ROUND: begin
          res_q <= res_c;
          state <= DONE;
        end
        DONE: begin
          div_output_q <= res_q;
          done_q       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Bench for fp16_div_seq: exact rational reference model, directed cases,
// randomized operands with start noise while busy, mid-operation reset.
module tb_fp16_div_seq;
  logic clk = 1'b0;
  logic rst;
  fp16_div_seq_if bus();

  fp16_div_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] exp; int n; } exp_t;
  exp_t q[$];

`ifdef FDIV_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int msb(input longint v);
    int r = 0;
    for (int i = 0; i < 12; i++) if (v[i]) r = i;
    return r;
  endfunction

  // exact quotient of two binary16 values, rounded to nearest even
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    logic s;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint ma, mb, num, den, r, r2, bits;
    int ea, eb, k, e, sh;
    s      = a[15] ^ b[15];
    nan_a  = (a[14:10] == 31) && (a[9:0] != 0);
    nan_b  = (b[14:10] == 31) && (b[9:0] != 0);
    inf_a  = (a[14:10] == 31) && (a[9:0] == 0);
    inf_b  = (b[14:10] == 31) && (b[9:0] == 0);
    zero_a = (a[14:10] == 0) && ((a[9:0] == 0) || !SUB_EN);
    zero_b = (b[14:10] == 0) && ((b[9:0] == 0) || !SUB_EN);
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) return 16'h7E00;
    if (inf_a || zero_b) return {s, 15'h7C00};
    if (zero_a || inf_b) return {s, 15'h0000};
    ma = (a[14:10] == 0) ? longint'(a[9:0]) : longint'(a[9:0]) + 1024;
    mb = (b[14:10] == 0) ? longint'(b[9:0]) : longint'(b[9:0]) + 1024;
    ea = ((a[14:10] == 0) ? 1 : int'(a[14:10])) - 25;
    eb = ((b[14:10] == 0) ? 1 : int'(b[14:10])) - 25;
    k = msb(ma) - msb(mb);
    if (k >= 0) begin
      if (ma < (mb << k)) k--;
    end else begin
      if ((ma << (-k)) < mb) k--;
    end
    e = k + ea - eb;
    if (e < -14) begin
      if (!SUB_EN) return {s, 15'h0000};
      e = -14;
    end
    sh  = ea - eb - e + 10;
    num = (sh >= 0) ? (ma << sh) : ma;
    den = (sh >= 0) ? mb : (mb << (-sh));
    r   = num / den;
    r2  = 2 * (num % den);
    if ((r2 > den) || ((r2 == den) && r[0])) r++;
    bits = (longint'(e + 14) << 10) + r;
    if (bits >= 64'h7C00) return {s, 15'h7C00};
    return {s, bits[14:0]};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [4:0] e;
    logic [9:0] m;
    case ($urandom_range(0, 9))
      0: e = 5'd0;
      1: e = 5'd31;
      2: e = 5'd1;
      3: e = 5'd30;
      4: e = 5'($urandom_range(1, 6));
      5: e = 5'($urandom_range(24, 30));
      default: e = 5'($urandom);
    endcase
    m = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom);
    return {1'($urandom), e, m};
  endfunction

  // every done pulse must match the oldest outstanding op, 17 edges after acceptance
  always @(negedge clk) begin
    if (bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 expected=0 cycle=%0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 32'(cyc - e.n), 32'd17);
        chk("result_vs_model", {16'd0, bus.div_output}, {16'd0, e.exp});
      end
    end
  end

  // noise: 0 start low while busy, 1 random start, 2 start held high
  task automatic do_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                       input int noise, input bit use_lit, input logic [15:0] lit);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.input_a = av; bus.input_b = bv;
    @(posedge clk); #1;
    e.n = cyc; e.exp = model(av, bv);
    q.push_back(e);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0)  chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
      if (i == 16) chk("busy_in_done_state", {31'd0, bus.busy}, 32'd1);
      bus.start   = (noise == 2) ? 1'b1 : ((noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.input_a = 16'($urandom);
      bus.input_b = 16'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_at_17", {31'd0, bus.done}, 32'd1);
    chk("busy_after_done_state", {31'd0, bus.busy}, 32'd0);
    if (use_lit) chk(nm, {16'd0, bus.div_output}, {16'd0, lit});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.input_a = 16'h0; bus.input_b = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_div_output", {16'd0, bus.div_output}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;

    // pin the reference model with hand-computed quotients
    chk("model_1_div_2", {16'd0, model(16'h3C00, 16'h4000)}, 32'h3800);
    chk("model_1_div_3", {16'd0, model(16'h3C00, 16'h4200)}, 32'h3555);
    chk("model_ovf",     {16'd0, model(16'h7BFF, 16'h3800)}, 32'h7C00);
    chk("model_sub_tie", {16'd0, model(16'h0003, 16'h4000)}, SUB_EN ? 32'h0002 : 32'h0000);

    do_op("one_half",    16'h3C00, 16'h4000, 0, 1'b1, 16'h3800);
    do_op("one_third",   16'h3C00, 16'h4200, 0, 1'b1, 16'h3555);
    do_op("six_three",   16'h4600, 16'h4200, 0, 1'b1, 16'h4000);
    do_op("pos_div0",    16'h4000, 16'h0000, 0, 1'b1, 16'h7C00);
    do_op("neg_div0",    16'hC000, 16'h0000, 0, 1'b1, 16'hFC00);
    do_op("zero_zero",   16'h0000, 16'h0000, 0, 1'b1, 16'h7E00);
    do_op("overflow",    16'h7BFF, 16'h3800, 0, 1'b1, 16'h7C00);
    do_op("inf_inf",     16'h7C00, 16'hFC00, 0, 1'b1, 16'h7E00);
    do_op("nan_in",      16'h7E01, 16'h3C00, 0, 1'b1, 16'h7E00);
    do_op("x_div_inf",   16'hC200, 16'h7C00, 0, 1'b1, 16'h8000);
    do_op("sub_tie",     16'h0003, 16'h4000, 0, 1'b1, SUB_EN ? 16'h0002 : 16'h0000);
    do_op("start_held",  16'h3C00, 16'h4200, 2, 1'b1, 16'h3555);
    do_op("after_held",  16'h4600, 16'h4200, 0, 1'b1, 16'h4000);

    // reset during DIVIDE, with start asserted on the reset edge
    @(negedge clk);
    bus.start = 1'b1; bus.input_a = 16'h3C00; bus.input_b = 16'h4200;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    chk("rst_div_output", {16'd0, bus.div_output}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0; bus.start = 1'b0;
    repeat (25) @(negedge clk);
    do_op("post_rst", 16'h3C00, 16'h4000, 0, 1'b1, 16'h3800);

    for (int t = 0; t < 200; t++) begin
      do_op("rand", rnd_op(), rnd_op(), 1, 1'b0, 16'h0000);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp16_div_seq.md
FP16_DIV_SEQ -- requirements
Module: fp16_div_seq

Interface
REQ-001 clk  input  1  rising-edge clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 input_a  input  16  IEEE-754 binary16 dividend.
REQ-005 input_b  input  16  IEEE-754 binary16 divisor.
REQ-006 div_output  output  16  binary16 quotient; registered; held until the next completion.
REQ-007 busy  output  1  high from the cycle after start is accepted through the DONE cycle.
REQ-008 done  output  1  one-cycle pulse; div_output is valid in that cycle.

Function
REQ-009 The block SHALL use FSM states IDLE -> UNPACK -> DIVIDE -> ROUND -> DONE -> IDLE.
REQ-010 In IDLE with start=1, the block SHALL latch input_a and input_b and enter UNPACK; later input changes SHALL be ignored.
REQ-011 Start SHALL be ignored in every state other than IDLE; there is no queueing.
REQ-012 UNPACK (1 cycle) SHALL:
- extract signs, exponents and mantissas with hidden bit;
- normalize subnormal operands by leading-zero shift;
- form the result sign as XOR of the operand signs;
- form the biased exponent as ea-eb+15;
- classify special cases.
REQ-013 DIVIDE SHALL run exactly 14 cycles of restoring division, producing 1 quotient bit per cycle, MSB first, using the counter div_cnt (4 bits, 13 down to 0).
REQ-014 ROUND (1 cycle) SHALL:
- normalize the quotient by 1 left shift if its MSB=0, decrementing the exponent;
- set sticky from a nonzero remainder;
- round to nearest, ties to even;
- re-normalize on mantissa carry-out.
REQ-015 If the final exponent is <=0, the result SHALL be right-shifted into subnormal form, with shifted-out bits ORed into sticky, before rounding.
REQ-016 A final exponent >=31 after rounding SHALL produce signed infinity (s,7C00).
REQ-017 Special cases SHALL be handled as follows:
- NaN operand, 0/0 or inf/inf -> 7E00;
- x/0 with x finite nonzero -> signed infinity;
- inf/x with x finite -> signed infinity;
- 0/x or x/inf -> signed zero.
REQ-018 Special cases SHALL still traverse all states; latency is fixed.
REQ-019 Latency SHALL be 17 cycles: start sampled at edge N gives done=1 and a valid div_output in the cycle after edge N+17.
REQ-020 In DONE, the block SHALL register div_output and assert done for exactly one cycle, then return to IDLE.
REQ-021 Start asserted in the DONE cycle SHALL be ignored; back-to-back throughput is 1 operation per 18 cycles.

Reset
REQ-022 rst=1 SHALL force the following on the same edge:
- state=IDLE, div_cnt=0;
- div_output=16'h0000;
- busy=0, done=0;
- internal operand and remainder registers cleared.
REQ-023 rst asserted mid-operation SHALL abort the operation with no done pulse; a start sampled in the same cycle as rst SHALL be ignored.

Configuration
REQ-024 Macro FDIV_SUBNORMAL_EN SHALL select subnormal handling.
REQ-025 With FDIV_SUBNORMAL_EN defined:
- subnormal inputs are normalized (REQ-012);
- subnormal results are produced per REQ-015.
REQ-026 Without FDIV_SUBNORMAL_EN:
- subnormal inputs are treated as signed zero;
- results with final exponent <=0 are flushed to signed zero;
- latency is unchanged.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- 3C00 / 4000 -> 3800 (1/2), done at start+17.
- 3C00 / 4200 -> 3555 (1/3, round to nearest even); 4600 / 4200 -> 4000.
- 4000 / 0000 -> 7C00; C000 / 0000 -> FC00; 0000 / 0000 -> 7E00; 7BFF / 3800 -> 7C00 (overflow).
- 0003 / 4000 -> 0002 with FDIV_SUBNORMAL_EN (tie to even); -> 0000 without it.
- start held high through a whole operation with inputs changed after acceptance -> one done pulse, result uses the latched inputs, next op starts at IDLE.
- rst pulsed at DIVIDE cycle 5 -> no done pulse, div_output=0000, busy=0 next cycle; a following op 3C00/4000 -> 3800.
